// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer: op codes, size codes, FSM encoding
// and the count-reduction helper used at request accept.
package shift_sequencer_pkg;

    localparam logic [3:0] SH_ROL  = 4'd0;
    localparam logic [3:0] SH_ROR  = 4'd1;
    localparam logic [3:0] SH_RCL  = 4'd2;
    localparam logic [3:0] SH_RCR  = 4'd3;
    localparam logic [3:0] SH_SHL  = 4'd4;
    localparam logic [3:0] SH_SHR  = 4'd5;
    localparam logic [3:0] SH_SAL  = 4'd6;
    localparam logic [3:0] SH_SAR  = 4'd7;
    localparam logic [3:0] SH_SHRD = 4'd8;
    localparam logic [3:0] SH_SHLD = 4'd9;

    localparam logic [3:0] SZ_BYTE  = 4'd1;
    localparam logic [3:0] SZ_WORD  = 4'd2;
    localparam logic [3:0] SZ_DWORD = 4'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
    } sb_res_t;

    // Rotate-through-carry cycles every width+1 positions, so narrow rcl/rcr
    // counts are folded before iterating.
    function automatic logic [4:0] eff_count(input logic [3:0] op,
                                             input logic [3:0] sz,
                                             input logic [4:0] raw);
        logic [4:0] n;
        n = raw;
        if (op == SH_RCL || op == SH_RCR) begin
            if (sz == SZ_BYTE) begin
                if (n >= 5'd27)      n = n - 5'd27;
                else if (n >= 5'd18) n = n - 5'd18;
                else if (n >= 5'd9)  n = n - 5'd9;
            end else if (sz == SZ_WORD) begin
                if (n >= 5'd17) n = n - 5'd17;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/shift_sequencer_shiftbox.sv
// Combinational shiftbox: one-position and four-position results for the
// selected op and operand size; bits above the operand size pass through.
module shift_sequencer_shiftbox
    import shift_sequencer_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [3:0]  sz,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        ci,
    output logic [31:0] resa,
    output logic [31:0] resb,
    output logic        co,
    output logic [31:0] resa4,
    output logic [31:0] resb4,
    output logic        co4
);

    function automatic sb_res_t step(input logic [3:0]  fop,
                                     input logic [3:0]  fsz,
                                     input logic [31:0] fa,
                                     input logic [31:0] fb,
                                     input logic        fci);
        logic [31:0] m, mb, lo, blo, left, right, x, nb;
        logic        amsb, bmsb, c;
        sb_res_t     r;
        case (fsz)
            SZ_BYTE: begin m = 32'h0000_00FF; mb = 32'h0000_0080; end
            SZ_WORD: begin m = 32'h0000_FFFF; mb = 32'h0000_8000; end
            default: begin m = 32'hFFFF_FFFF; mb = 32'h8000_0000; end
        endcase
        lo    = fa & m;
        blo   = fb & m;
        amsb  = |(lo & mb);
        bmsb  = |(blo & mb);
        left  = (lo << 1) & m;
        right = lo >> 1;
        x     = lo;
        nb    = blo;
        c     = fci;
        case (fop)
            SH_ROL:         x = left | {31'b0, amsb};
            SH_ROR:         x = right | (fa[0] ? mb : 32'h0);
            SH_RCL:  begin  x = left | {31'b0, fci};      c = amsb;  end
            SH_RCR:  begin  x = right | (fci ? mb : 32'h0); c = fa[0]; end
            SH_SHL,
            SH_SAL:  begin  x = left;                     c = amsb;  end
            SH_SHR:         x = right;
            SH_SAR:         x = right | (amsb ? mb : 32'h0);
            // Double shifts feed the vacated position from b and shift b
            // along so the next step sees its next bit.
            SH_SHRD: begin
                x  = right | (fb[0] ? mb : 32'h0);
                c  = fa[0];
                nb = blo >> 1;
            end
            SH_SHLD: begin
                x  = left | {31'b0, bmsb};
                c  = amsb;
                nb = (blo << 1) & m;
            end
            default: ;
        endcase
        r.a = (fa & ~m) | x;
        r.b = (fb & ~m) | nb;
        r.c = c;
        return r;
    endfunction

    sb_res_t s1, s2, s3, s4;

    assign s1 = step(op, sz, a, b, ci);
    assign s2 = step(op, sz, s1.a, s1.b, s1.c);
    assign s3 = step(op, sz, s2.a, s2.b, s2.c);
    assign s4 = step(op, sz, s3.a, s3.b, s3.c);

    assign resa  = s1.a;
    assign resb  = s1.b;
    assign co    = s1.c;
    assign resa4 = s4.a;
    assign resb4 = s4.b;
    assign co4   = s4.c;

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift/rotate sequencer: iterates the shiftbox four or one
// positions per clock and pulses done when the effective count is consumed.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             flush,
    input  logic [3:0]       shiftop,
    input  logic [3:0]       calc_sz,
    input  logic [CNT_W-1:0] count,
    input  logic             ci,
    input  logic [31:0]      opa,
    input  logic [31:0]      opb,
    output logic             busy,
    output logic             done,
    output logic [31:0]      resa,
    output logic [31:0]      resb,
    output logic             co,
    output logic             cnt_zero,
    output logic             cnt_one
);

    state_t      state;
    logic [3:0]  op_q;
    logic [3:0]  sz_q;
    logic [4:0]  rem;
    logic [4:0]  rem_next;
    logic [4:0]  n_eff;
    logic        wide;
    logic [31:0] sa1, sb1, sa4, sb4;
    logic        sc1, sc4;
    logic        cnt_unused;

    assign cnt_unused = ^count[CNT_W-1:5];
    assign n_eff      = eff_count(shiftop, calc_sz, count[4:0]);
    assign wide       = (rem >= 5'd4);
    assign rem_next   = wide ? rem - 5'd4 : ((rem == 5'd0) ? 5'd0 : rem - 5'd1);

    shift_sequencer_shiftbox u_shiftbox (
        .op    (op_q),
        .sz    (sz_q),
        .a     (resa),
        .b     (resb),
        .ci    (co),
        .resa  (sa1),
        .resb  (sb1),
        .co    (sc1),
        .resa4 (sa4),
        .resb4 (sb4),
        .co4   (sc4)
    );

    // A zero count still spends one RUN cycle without stepping, so done
    // always lands at least one edge after accept.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            op_q     <= 4'd0;
            sz_q     <= 4'd0;
            rem      <= 5'd0;
            resa     <= 32'h0;
            resb     <= 32'h0;
            co       <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
            cnt_zero <= 1'b0;
            cnt_one  <= 1'b0;
        end else if (flush) begin
            state <= IDLE;
            rem   <= 5'd0;
            done  <= 1'b0;
            busy  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (rem != 5'd0) begin
                        resa <= wide ? sa4 : sa1;
                        resb <= wide ? sb4 : sb1;
                        co   <= wide ? sc4 : sc1;
                    end
                    rem <= rem_next;
                    if (rem_next == 5'd0) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state    <= RUN;
                        busy     <= 1'b1;
                        op_q     <= shiftop;
                        sz_q     <= calc_sz;
                        rem      <= n_eff;
                        resa     <= opa;
                        resb     <= opb;
                        co       <= ci;
                        cnt_zero <= (n_eff == 5'd0);
                        cnt_one  <= (n_eff == 5'd1);
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_shift_sequencer.sv
// Scoreboard bench for shift_sequencer: expected results are queued at accept
// and compared (value and latency) when done pulses.
module tb_shift_sequencer;

    logic        clk, rst, start, flush, ci;
    logic [3:0]  shiftop, calc_sz;
    logic [7:0]  count;
    logic [31:0] opa, opb;
    logic        busy, done, co, cnt_zero, cnt_one;
    logic [31:0] resa, resb;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit prev_done = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        c;
        logic        cz;
        logic        c1;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    shift_sequencer #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .flush(flush),
        .shiftop(shiftop), .calc_sz(calc_sz), .count(count), .ci(ci),
        .opa(opa), .opb(opb), .busy(busy), .done(done),
        .resa(resa), .resb(resb), .co(co),
        .cnt_zero(cnt_zero), .cnt_one(cnt_one)
    );

    initial clk = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            tests++;
            if (prev_done) begin
                fails++;
                $display("FAIL done_pulse: done high on two consecutive cycles, required one-cycle pulse");
            end
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: done=1 with no request outstanding, required done=0");
            end else begin
                e = sb.pop_front();
                if ({resa, resb, co, cnt_zero, cnt_one} !== {e.a, e.b, e.c, e.cz, e.c1}) begin
                    fails++;
                    $display("FAIL %s: resa=%h resb=%h co=%b cz=%b c1=%b, required %h %h %b %b %b",
                             e.name, resa, resb, co, cnt_zero, cnt_one, e.a, e.b, e.c, e.cz, e.c1);
                end
                tests++;
                if (cyc != e.due) begin
                    fails++;
                    $display("FAIL %s_latency: done at cycle %0d, required cycle %0d", e.name, cyc, e.due);
                end
            end
        end
        prev_done = done;
    end

    function automatic int eff_n(input logic [3:0] op, input logic [3:0] sz, input logic [7:0] cnt);
        int n;
        n = cnt % 32;
        if (op == 2 || op == 3) begin
            if (sz == 1) n = n % 9;
            else if (sz == 2) n = n % 17;
        end
        return n;
    endfunction

    // Reference: n single-position shifts with x86-like semantics
    function automatic void model(input logic [3:0] op, input logic [3:0] sz, input int n,
                                  input logic cin, input logic [31:0] a0, input logic [31:0] b0,
                                  output logic [31:0] ra, output logic [31:0] rb, output logic c);
        logic [31:0] m, x, y, a, b;
        logic        am;
        int          msb;
        msb = (sz == 1) ? 7 : (sz == 2) ? 15 : 31;
        m = (msb == 31) ? 32'hFFFF_FFFF : ((32'h1 << (msb + 1)) - 1);
        a = a0; b = b0; c = cin;
        for (int i = 0; i < n; i++) begin
            x = a & m; y = b & m; am = x[msb];
            case (op)
                0: x = ((x << 1) | {31'b0, am}) & m;
                1: x = (x >> 1) | ({31'b0, a[0]} << msb);
                2: begin x = ((x << 1) | {31'b0, c}) & m; c = am; end
                3: begin x = (x >> 1) | ({31'b0, c} << msb); c = a[0]; end
                4, 6: begin x = (x << 1) & m; c = am; end
                5: x = x >> 1;
                7: x = (x >> 1) | ({31'b0, am} << msb);
                8: begin x = (x >> 1) | ({31'b0, b[0]} << msb); c = a[0]; y = y >> 1; end
                9: begin x = ((x << 1) | {31'b0, y[msb]}) & m; c = am; y = (y << 1) & m; end
                default: ;
            endcase
            a = (a & ~m) | x;
            b = (b & ~m) | y;
        end
        ra = a; rb = b;
    endfunction

    // Called on a negedge; returns on the negedge after the accept edge.
    task automatic issue(input logic [3:0] op, input logic [3:0] sz, input logic [7:0] cnt,
                         input logic cin, input logic [31:0] a, input logic [31:0] b, input bit push,
                         input logic [31:0] ra, input logic [31:0] rb, input logic c, input string name);
        exp_t e;
        int   n, lat;
        n   = eff_n(op, sz, cnt);
        lat = n / 4 + n % 4;
        if (lat < 1) lat = 1;
        shiftop = op; calc_sz = sz; count = cnt; ci = cin; opa = a; opb = b; start = 1;
        @(posedge clk);
        #1;
        if (push) begin
            e.a = ra; e.b = rb; e.c = c; e.cz = (n == 0); e.c1 = (n == 1);
            e.due = cyc + lat; e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 0;
    endtask

    task automatic issue_model(input logic [3:0] op, input logic [3:0] sz, input logic [7:0] cnt,
                               input logic cin, input logic [31:0] a, input logic [31:0] b, input string name);
        logic [31:0] ra, rb;
        logic        c;
        model(op, sz, eff_n(op, sz, cnt), cin, a, b, ra, rb, c);
        issue(op, sz, cnt, cin, a, b, 1, ra, rb, c, name);
    endtask

    task automatic wait_done(input int budget, input string name);
        int k = 0;
        while (!done && k < budget) begin
            @(negedge clk);
            k++;
        end
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL %s_timeout: done=0 after %0d cycles, required done=1", name, budget);
        end
    endtask

    task automatic test_reset();
        rst = 1; start = 0; flush = 0; shiftop = 0; calc_sz = 4; count = 0; ci = 0; opa = 0; opb = 0;
        repeat (2) @(negedge clk);
        tests++;
        if ({resa, resb, co, done, busy, cnt_zero, cnt_one} !== 69'h0) begin
            fails++;
            $display("FAIL reset: resa=%h resb=%h co=%b done=%b busy=%b cz=%b c1=%b, required all 0",
                     resa, resb, co, done, busy, cnt_zero, cnt_one);
        end
        rst = 0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL reset_idle: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    task automatic test_vectors();
        issue(0, 4, 8'd1, 0, 32'h8000_0001, 32'h0, 1, 32'h0000_0003, 32'h0, 0, "rol_1");
        wait_done(10, "rol_1"); @(negedge clk);
        issue(4, 4, 8'd9, 0, 32'h0000_00FF, 32'h0, 1, 32'h0001_FE00, 32'h0, 0, "shl_9");
        wait_done(10, "shl_9"); @(negedge clk);
        issue(4, 4, 8'h20, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1, 32'hDEAD_BEEF, 32'h1234_5678, 1, "shl_mask0");
        wait_done(10, "shl_mask0"); @(negedge clk);
        issue(2, 1, 8'd1, 0, 32'h1234_5681, 32'h0, 1, 32'h1234_5602, 32'h0, 1, "rcl8_1");
        wait_done(10, "rcl8_1"); @(negedge clk);
        issue(2, 1, 8'd9, 0, 32'h1234_5681, 32'h0, 1, 32'h1234_5681, 32'h0, 0, "rcl8_9");
        wait_done(10, "rcl8_9"); @(negedge clk);
        issue(7, 2, 8'd7, 1, 32'h1234_8000, 32'h0, 1, 32'h1234_FF00, 32'h0, 1, "sar16_7");
        wait_done(10, "sar16_7"); @(negedge clk);
    endtask

    task automatic test_hold();
        issue(4, 4, 8'd4, 0, 32'h0F0F_0F0F, 32'h5555_AAAA, 1, 32'hF0F0_F0F0, 32'h5555_AAAA, 0, "shl_4");
        wait_done(10, "shl_4");
        repeat (5) @(negedge clk);
        tests++;
        if (resa !== 32'hF0F0_F0F0 || busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL hold: resa=%h busy=%b done=%b, required f0f0f0f0 0 0", resa, busy, done);
        end
    endtask

    task automatic test_random();
        logic [3:0] op, sz;
        logic [7:0] cnt;
        for (int i = 0; i < 20; i++) begin
            op  = 4'($urandom_range(0, 9));
            sz  = (i % 3 == 0) ? 4'd1 : (i % 3 == 1) ? 4'd2 : 4'd4;
            cnt = 8'($urandom_range(0, 255));
            if (op >= 8 && sz == 2 && (cnt % 32) > 16) cnt = cnt & 8'h0F;
            issue_model(op, sz, cnt, 1'($urandom_range(0, 1)), $urandom, $urandom, "random");
            wait_done(20, "random");
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        issue_model(9, 4, 8'd6, 0, 32'h8123_4567, 32'hF000_0001, "b2b_shld");
        wait_done(20, "b2b_shld");
        issue_model(3, 2, 8'd0, 1, 32'hAAAA_5555, 32'h0, "b2b_rcr0");
        wait_done(20, "b2b_rcr0");
        issue_model(8, 4, 8'd13, 1, 32'h0000_FFFF, 32'h1357_9BDF, "b2b_shrd");
        wait_done(20, "b2b_shrd");
        @(negedge clk);
    endtask

    task automatic test_start_in_run();
        issue(0, 4, 8'd31, 1, 32'h8000_0001, 32'h0, 1, 32'hC000_0000, 32'h0, 1, "rol_31");
        repeat (3) @(negedge clk);
        start = 1; opa = 32'hFFFF_0000; count = 8'd1;
        @(negedge clk);
        start = 0;
        wait_done(20, "rol_31");
        repeat (4) @(negedge clk);
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL start_in_run_dropped: busy=%b after completion, required 0", busy);
        end
    endtask

    task automatic test_flush();
        issue(0, 4, 8'd31, 0, 32'h1234_5678, 32'h0, 0, 32'h0, 32'h0, 0, "flush");
        repeat (2) @(negedge clk);
        tests++;
        if (busy !== 1'b1) begin
            fails++;
            $display("FAIL flush_busy_run: busy=%b during RUN, required 1", busy);
        end
        flush = 1;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle: busy=%b done=%b, required 0 0", busy, done);
        end
        @(negedge clk);
        flush = 0;
        repeat (12) @(negedge clk);
        start = 1; flush = 1; count = 8'd5;
        @(posedge clk); #1;
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_start_same: busy=%b, required 0 (start dropped)", busy);
        end
        @(negedge clk);
        start = 0; flush = 0;
        repeat (8) @(negedge clk);
    endtask

    task automatic test_rst_mid_run();
        issue(0, 4, 8'd31, 1, 32'hCAFE_F00D, 32'h1111_2222, 0, 32'h0, 32'h0, 0, "rst");
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        tests++;
        if ({resa, resb, co, done, busy, cnt_zero, cnt_one} !== 69'h0) begin
            fails++;
            $display("FAIL rst_mid_run: resa=%h resb=%h co=%b done=%b busy=%b cz=%b c1=%b, required all 0",
                     resa, resb, co, done, busy, cnt_zero, cnt_one);
        end
        @(negedge clk);
        rst = 0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_hold();
        test_random();
        test_back_to_back();
        test_start_in_run();
        test_flush();
        test_rst_mid_run();
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results outstanding, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
